// File: rtl/mul_share_ctrl_if.sv
// Request/response bundle between two multiply clients, the consumer and the shared multiplier scheduler.
interface mul_share_ctrl_if #(
  parameter int unsigned W = 8
);
  logic           req0_valid;
  logic           req0_ready;
  logic [W-1:0]   req0_x;
  logic [W-1:0]   req0_y;
  logic           req1_valid;
  logic           req1_ready;
  logic [W-1:0]   req1_x;
  logic [W-1:0]   req1_y;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [2*W-1:0] rsp_res;

  modport master (
    output req0_valid, req0_x, req0_y,
    output req1_valid, req1_x, req1_y,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_res
  );

  modport slave (
    input  req0_valid, req0_x, req0_y,
    input  req1_valid, req1_x, req1_y,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_res
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin scheduler sharing one repeated-addition multiplier between two requesters.
module mul_share_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             reset,
  mul_share_ctrl_if.slave  bus,
  output logic             busy
);
  localparam int unsigned RW = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_acc;
  logic [W-1:0]    r_cnt;
  logic [W-1:0]    r_x;
  logic [W-1:0]    r_y;
  logic            r_id;
  logic            r_last_grant;
  logic            r_rsp_valid;
  logic            r_rsp_id;
  logic [RW-1:0]   r_rsp_res;
  logic            r_busy;

  logic            w_grant0;
  logic            w_grant1;
  logic            w_acc0;
  logic            w_acc1;

  // Lone requester wins outright; on contention the one not served last wins.
  assign w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
  assign w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
  assign w_acc0   = (r_state == IDLE) && w_grant0;
  assign w_acc1   = (r_state == IDLE) && w_grant1;

  assign bus.req0_ready = w_acc0;
  assign bus.req1_ready = w_acc1;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_res    = r_rsp_res;
  assign busy           = r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_res    <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc0 || w_acc1) begin
            r_x          <= w_acc0 ? bus.req0_x : bus.req1_x;
            r_y          <= w_acc0 ? bus.req0_y : bus.req1_y;
            r_id         <= w_acc1;
            r_last_grant <= w_acc1;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_state      <= RUN;
            r_busy       <= 1'b1;
          end
        end
        RUN: begin
          if (r_cnt != r_y) begin
            r_acc <= r_acc + RW'(r_x);
            r_cnt <= r_cnt + W'(1);
          end else begin
            r_rsp_res   <= r_acc;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
